// File: rtl/mem_req_buffer.sv
// mem_req_buffer: request FIFO and single-outstanding issue stage in front of a memory controller
//
// Ports:
//   clk, nReset                    clock (rising edge), asynchronous active-low reset
//   reqValid/reqReady              upstream request handshake; reqReady drops only when the FIFO is full
//   reqAddr/reqWData/reqWrite      request payload (reqWrite=1 write, 0 read)
//   memAddr/memWData/memWrite      payload toward the controller, held while memReq=1
//   memReq                         transaction active toward the controller
//   memResp/memRData               controller status (00 IDLE, 01 BUSY, 10 DONE, 11 ERR) and read data
//   rspValid/rspReady              downstream response handshake
//   rspData/rspErr                 read data (0 for writes/errors), status (00 ok, 01 ERR, 10 timeout)
module mem_req_buffer #(
   parameter int DataWidth = 32,
   parameter int AddrWidth = 32,
   parameter int Depth     = 4,
   parameter int Timeout   = 64
) (
   input  logic                 clk,
   input  logic                 nReset,
   input  logic                 reqValid,
   output logic                 reqReady,
   input  logic [AddrWidth-1:0] reqAddr,
   input  logic [DataWidth-1:0] reqWData,
   input  logic                 reqWrite,
   output logic [AddrWidth-1:0] memAddr,
   output logic [DataWidth-1:0] memWData,
   output logic                 memWrite,
   output logic                 memReq,
   input  logic [1:0]           memResp,
   input  logic [DataWidth-1:0] memRData,
   output logic                 rspValid,
   input  logic                 rspReady,
   output logic [DataWidth-1:0] rspData,
   output logic [1:0]           rspErr
);
   localparam int PW = $clog2(Depth) + 1;
   localparam int EW = AddrWidth + DataWidth + 1;
   localparam int WW = $clog2(Timeout + 1);
   localparam logic [1:0] RESP_DONE = 2'b10;
   localparam logic [1:0] RESP_ERR  = 2'b11;

   typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

   state_t        state;
   logic [EW-1:0] fifo [Depth];
   logic [PW-1:0] wptr, rptr;
   logic [WW-1:0] wd;
   logic [EW-1:0] head;
   logic          empty, full, push, pop, finish;

   // Pointers carry one extra wrap bit so full and empty are distinguishable.
   // A pop happens when idle, or straight out of RESP on the response handshake.
   always_comb begin
      empty  = wptr == rptr;
      full   = wptr == {~rptr[PW-1], rptr[PW-2:0]};
      push   = reqValid && !full;
      pop    = !empty && (state == IDLE || (state == RESP && rspReady));
      head   = fifo[rptr[PW-2:0]];
      finish = memResp == RESP_DONE || memResp == RESP_ERR || wd == WW'(Timeout - 1);
   end

   assign reqReady = !full;

   always_ff @(posedge clk)
      if (push) fifo[wptr[PW-2:0]] <= {reqWrite, reqWData, reqAddr};

   always_ff @(posedge clk or negedge nReset)
      if (!nReset) begin
         wptr <= '0;
         rptr <= '0;
      end else begin
         wptr <= wptr + PW'(push);
         rptr <= rptr + PW'(pop);
      end

   always_ff @(posedge clk or negedge nReset) begin
      if (!nReset) begin
         state    <= IDLE;
         memReq   <= 1'b0;
         memAddr  <= '0;
         memWData <= '0;
         memWrite <= 1'b0;
         rspValid <= 1'b0;
         rspData  <= '0;
         rspErr   <= 2'b00;
         wd       <= '0;
      end else begin
         if (pop) begin
            {memWrite, memWData, memAddr} <= head;
            memReq <= 1'b1;
            state  <= ISSUE;
         end
         case (state)
            ISSUE: begin
               wd    <= '0;
               state <= WAIT;
            end
            // DONE beats ERR beats the watchdog when they coincide.
            WAIT: begin
               wd <= wd + WW'(1);
               if (finish) begin
                  memReq   <= 1'b0;
                  rspValid <= 1'b1;
                  state    <= RESP;
                  rspErr   <= memResp == RESP_DONE ? 2'b00 : memResp == RESP_ERR ? 2'b01 : 2'b10;
                  rspData  <= memResp == RESP_DONE && !memWrite ? memRData : '0;
               end
            end
            RESP:
               if (rspReady) begin
                  rspValid <= 1'b0;
                  if (empty) state <= IDLE;
               end
            default: ;
         endcase
      end
   end
endmodule

// File: tb/tb_mem_req_buffer.sv
// tb_mem_req_buffer: randomized self-checking bench for mem_req_buffer against a transaction-level model
module tb_mem_req_buffer;
   localparam int DW = 32;
   localparam int AW = 32;
   localparam int D  = 4;
   localparam int T  = 64;

   logic          clk = 1'b0;
   logic          nReset = 1'b0;
   logic          reqValid = 1'b0;
   logic          reqReady;
   logic [AW-1:0] reqAddr = '0;
   logic [DW-1:0] reqWData = '0;
   logic          reqWrite = 1'b0;
   logic [AW-1:0] memAddr;
   logic [DW-1:0] memWData;
   logic          memWrite;
   logic          memReq;
   logic [1:0]    memResp = 2'b00;
   logic [DW-1:0] memRData = '0;
   logic          rspValid;
   logic          rspReady = 1'b0;
   logic [DW-1:0] rspData;
   logic [1:0]    rspErr;

   always #5 clk = ~clk;

   mem_req_buffer #(.DataWidth(DW), .AddrWidth(AW), .Depth(D), .Timeout(T)) dut (
      .clk(clk), .nReset(nReset),
      .reqValid(reqValid), .reqReady(reqReady), .reqAddr(reqAddr), .reqWData(reqWData), .reqWrite(reqWrite),
      .memAddr(memAddr), .memWData(memWData), .memWrite(memWrite), .memReq(memReq),
      .memResp(memResp), .memRData(memRData),
      .rspValid(rspValid), .rspReady(rspReady), .rspData(rspData), .rspErr(rspErr)
   );

   typedef struct packed {logic [AW-1:0] a; logic [DW-1:0] d; logic w;} req_t;
   // lat: BUSY/IDLE cycles in WAIT before the answer; ans 00 means the controller never answers
   typedef struct {int lat; logic [1:0] ans; logic [DW-1:0] rd; bit fix;} plan_t;

   req_t  stim[$];
   req_t  q[$];
   req_t  cur;
   plan_t plans[$];
   plan_t pl;
   int    n_vec = 0;
   int    n_err = 0;
   int    phase = 0;
   int    k = 0;
   int    kr = 0;
   int    req_pct = 100;
   int    rdy_pct = 100;
   bit    drv_valid = 0;
   bit    seen_ready = 0;
   bit    drv_rdy = 0;
   logic [DW-1:0] exp_data = '0;
   logic [1:0]    exp_err = 2'b00;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
      end
   endtask

   function automatic plan_t rand_plan();
      plan_t p;
      int r;
      r = $urandom_range(0, 99);
      p.ans = r < 65 ? 2'b10 : r < 92 ? 2'b11 : 2'b00;
      p.lat = $urandom_range(0, 6);
      p.rd = '0;
      p.fix = 0;
      r = $urandom_range(0, 99);
      if (r < 3) p.lat = T - 1;
      else if (r < 5) p.lat = T;
      return p;
   endfunction

   function automatic req_t rand_req();
      req_t r;
      r.a = $urandom;
      r.d = $urandom;
      r.w = 1'($urandom_range(0, 1));
      return r;
   endfunction

   task automatic start_txn();
      cur = q.pop_front();
      check("issue_addr", memAddr, cur.a);
      check("issue_wdata", memWData, cur.d);
      check("issue_write", memWrite, cur.w);
      pl = plans.size() > 0 ? plans.pop_front() : rand_plan();
      k = 0;
      exp_data = '0;
      if (pl.ans != 2'b00 && pl.lat + 1 <= T) begin
         kr = pl.lat + 2;
         exp_err = pl.ans == 2'b10 ? 2'b00 : 2'b01;
      end else begin
         kr = T + 1;
         exp_err = 2'b10;
      end
      phase = 1;
   endtask

   task automatic check_rsp();
      check("rspvalid", rspValid, 1);
      check("memreq_resp", memReq, 0);
      check("rspdata", rspData, exp_data);
      check("rsperr", rspErr, exp_err);
   endtask

   task automatic cycle();
      int qn;
      int old;
      bit acc;
      bit hs;
      @(negedge clk);
      qn  = q.size();
      old = phase;
      acc = drv_valid && seen_ready;
      hs  = old == 2 && drv_rdy;
      if (acc) q.push_back(stim.pop_front());
      if ((old == 0 || hs) && qn > 0) begin
         check("memreq_rise", memReq, 1);
         check("rspvalid_issue", rspValid, 0);
         start_txn();
      end else if (old == 0 || hs) begin
         phase = 0;
         check("memreq_idle", memReq, 0);
         check("rspvalid_idle", rspValid, 0);
      end else if (old == 1) begin
         k++;
         if (k < kr) begin
            check("memreq_wait", memReq, 1);
            check("rspvalid_wait", rspValid, 0);
            check("hold_addr", memAddr, cur.a);
            check("hold_write", memWrite, cur.w);
         end else begin
            phase = 2;
            check_rsp();
         end
      end else check_rsp();
      check("reqready", reqReady, 64'(q.size() < D));
      if (phase == 1 && k >= 1 && k == pl.lat + 1 && pl.ans != 2'b00) begin
         memResp = pl.ans;
         memRData = pl.fix ? pl.rd : DW'($urandom);
         if (pl.ans == 2'b10 && !cur.w) exp_data = memRData;
      end else begin
         memResp = phase == 1 && k >= 1 ? 2'($urandom_range(0, 1)) : 2'($urandom_range(0, 3));
         memRData = $urandom;
      end
      drv_rdy = $urandom_range(0, 99) < rdy_pct;
      rspReady = drv_rdy;
      drv_valid = (drv_valid && !acc) || (stim.size() > 0 && $urandom_range(0, 99) < req_pct);
      if (drv_valid) begin
         reqAddr = stim[0].a;
         reqWData = stim[0].d;
         reqWrite = stim[0].w;
      end else begin
         reqAddr = $urandom;
         reqWData = $urandom;
         reqWrite = 1'($urandom_range(0, 1));
      end
      reqValid = drv_valid;
      seen_ready = reqReady;
   endtask

   // Reset lands mid-cycle so memReq must fall without a clock edge.
   task automatic do_reset();
      @(negedge clk);
      #2;
      nReset = 1'b0;
      reqValid = 1'b1;
      #1;
      check("rst_memreq_async", memReq, 0);
      check("rst_rspvalid", rspValid, 0);
      check("rst_reqready", reqReady, 1);
      repeat (3) begin
         @(negedge clk);
         check("rst_hold_memreq", memReq, 0);
         check("rst_hold_rspvalid", rspValid, 0);
         check("rst_hold_reqready", reqReady, 1);
      end
      reqValid = 1'b0;
      rspReady = 1'b0;
      memResp = 2'b00;
      drv_valid = 0;
      drv_rdy = 0;
      seen_ready = 0;
      q.delete();
      stim.delete();
      plans.delete();
      phase = 0;
      nReset = 1'b1;
   endtask

   initial begin
      #500000;
      $display("FAIL global_timeout: simulation did not finish");
      $fatal(1);
   end

   initial begin
      bit got;
      do_reset();
      repeat (6) cycle();

      stim.push_back('{a: 32'h100, d: 32'h0, w: 1'b0});
      plans.push_back('{lat: 3, ans: 2'b10, rd: 32'hDEADBEEF, fix: 1});
      repeat (12) cycle();

      for (int i = 0; i < 5; i++) begin
         stim.push_back('{a: AW'(i), d: DW'(i), w: 1'b1});
         plans.push_back('{lat: i == 0 ? 20 : 1, ans: 2'b10, rd: '0, fix: 0});
      end
      repeat (60) cycle();

      stim.push_back('{a: 32'h200, d: 32'h0, w: 1'b0});
      stim.push_back('{a: 32'h204, d: 32'h0, w: 1'b0});
      plans.push_back('{lat: 0, ans: 2'b00, rd: '0, fix: 0});
      plans.push_back('{lat: 2, ans: 2'b10, rd: 32'hCAFEF00D, fix: 1});
      repeat (T + 20) cycle();

      stim.push_back('{a: 32'h300, d: 32'h0, w: 1'b0});
      stim.push_back('{a: 32'h304, d: 32'h0, w: 1'b0});
      plans.push_back('{lat: T - 1, ans: 2'b10, rd: 32'h12345678, fix: 1});
      plans.push_back('{lat: T, ans: 2'b11, rd: '0, fix: 0});
      repeat (2 * T + 20) cycle();

      stim.push_back('{a: 32'h400, d: 32'h55AA55AA, w: 1'b1});
      stim.push_back('{a: 32'h404, d: 32'h0, w: 1'b0});
      plans.push_back('{lat: 1, ans: 2'b11, rd: '0, fix: 0});
      plans.push_back('{lat: 0, ans: 2'b10, rd: '0, fix: 0});
      rdy_pct = 0;
      got = 0;
      for (int i = 0; i < 20 && !got; i++) begin
         cycle();
         got = phase == 2;
      end
      check("t5_resp_reached", got, 1);
      repeat (10) cycle();
      rdy_pct = 100;
      repeat (10) cycle();

      for (int i = 0; i < 4; i++) begin
         stim.push_back(rand_req());
         plans.push_back('{lat: 0, ans: 2'b00, rd: '0, fix: 0});
      end
      got = 0;
      for (int i = 0; i < 30 && !got; i++) begin
         cycle();
         got = phase == 1 && k >= 3 && q.size() == 3;
      end
      check("t6_wait_reached", got, 1);
      do_reset();
      repeat (20) cycle();

      req_pct = 40;
      rdy_pct = 60;
      for (int i = 0; i < 900; i++) begin
         if (stim.size() < 3 && $urandom_range(0, 3) == 0) stim.push_back(rand_req());
         cycle();
      end
      rdy_pct = 100;
      req_pct = 100;
      got = 0;
      for (int i = 0; i < 1500 && !got; i++) begin
         cycle();
         got = stim.size() == 0 && q.size() == 0 && phase == 0;
      end
      check("drained", got, 1);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule
